kbd_scan_ctrl: RTL

KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

---
 rtl/kbd_scan_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - PS/2 set-2 scancode decoder: pops the receive FIFO and tracks the held key
// Optional feature macro: KBD_ASCII_EN (registered set-2 to ASCII lookup on key_ascii)
module kbd_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky
);

  typedef enum logic {IDLE = 1'b0, POP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_ascii_q, key_ascii_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             ovf_q, ovf_d;

`ifdef KBD_ASCII_EN
  function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction
`endif

  // Pop strobe is decoded combinationally; gating with resetn keeps it high while in reset
  assign nextdata_n = ~(resetn & (state_q == IDLE) & ps2_ready);

  // Next-state: fetch a byte in IDLE, interpret it in POP
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_valid_d = key_valid_q;
    key_ascii_d = key_ascii_q;
    press_cnt_d = press_cnt_q;
    ovf_d       = ovf_q | ps2_overflow;
    case (state_q)
      IDLE: begin
        if (ps2_ready) begin
          byte_d  = ps2_data;
          state_d = POP;
        end
      end
      POP: begin
        state_d = IDLE;
        if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (!brk_q) begin
            // A matching held key is typematic repeat and leaves everything alone
            if (!key_valid_q || byte_q != key_code_q || ext_q != key_ext_q) begin
              key_code_d  = byte_q;
              key_ext_d   = ext_q;
              key_valid_d = 1'b1;
              press_cnt_d = press_cnt_q + CNT_W'(1);
`ifdef KBD_ASCII_EN
              key_ascii_d = ext_q ? 8'h00 : set2_to_ascii(byte_q);
`else
              key_ascii_d = 8'h00;
`endif
            end
          end else if (byte_q == key_code_q && ext_q == key_ext_q) begin
            // Break of an older, rolled-over key does not release the current one
            key_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_ascii_q <= 8'h00;
      press_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      key_ascii_q <= key_ascii_d;
      press_cnt_q <= press_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign key_valid  = key_valid_q;
  assign key_ascii  = key_ascii_q;
  assign press_cnt  = press_cnt_q;
  assign ovf_sticky = ovf_q;

endmodule
